// File: rtl/jb_dbgbuf_pkg.sv
// ----------------------------------------------------------------------------
// jb_dbgbuf_pkg
// Shared defaults and state encoding for the debug-buffer reader.
//   JB_AWIDTH_DEF      URAM word-address width
//   JB_DWIDTH_DEF      data width of the memory and the stream
//   JB_RD_LAT_DEF      cycles from mem_en to valid mem_dout
//   JB_FIFO_DEPTH_DEF  return-buffer depth (power of 2, >= RD_LAT+2)
//   JB_LEN_W           width of addresses, lengths and the word counter
//   jb_state_e         reader FSM states
// ----------------------------------------------------------------------------
package jb_dbgbuf_pkg;

  localparam int JB_AWIDTH_DEF     = 18;
  localparam int JB_DWIDTH_DEF     = 64;
  localparam int JB_RD_LAT_DEF     = 7;
  localparam int JB_FIFO_DEPTH_DEF = 16;
  localparam int JB_LEN_W          = 20;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } jb_state_e;

endpackage

// File: rtl/jb_dbgbuf_rd_fifo.sv
// ----------------------------------------------------------------------------
// jb_dbgbuf_rd_fifo
// Synchronous first-word-fall-through return buffer. The head word is always
// visible on dout while count is non-zero.
//   clk    in   clock
//   rst_n  in   synchronous reset, active low
//   clear  in   synchronous flush; wins over push and pop in the same cycle
//   push   in   write din (ignored when full)
//   din    in   write data
//   pop    in   drop the head word (ignored when empty)
//   dout   out  head word
//   count  out  number of stored words, 0..DEPTH
// ----------------------------------------------------------------------------
module jb_dbgbuf_rd_fifo
  import jb_dbgbuf_pkg::*;
#(
  parameter int DEPTH  = JB_FIFO_DEPTH_DEF,
  parameter int DWIDTH = JB_DWIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   push,
  input  logic [DWIDTH-1:0]      din,
  input  logic                   pop,
  output logic [DWIDTH-1:0]      dout,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_push = push && (count != FULL) && !clear;
  assign do_pop  = pop && (count != '0) && !clear;
  assign dout    = mem[rd_ptr];

  // Storage has no reset; count and pointers decide what is meaningful.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/jb_dbgbuf_reader.sv
// ----------------------------------------------------------------------------
// jb_dbgbuf_reader
// Streams rd_len words from a read-only URAM port starting at start_addr.
// Reads are issued only while in-flight plus buffered words leave room in the
// return FIFO, so any amount of stream backpressure is absorbed losslessly.
//
// Optional feature macro: JB_DBGBUF_RD_CNT_EN
//   defined   -> rd_cnt counts accepted stream words (cleared on start,
//                saturating at 0xFFFFF)
//   undefined -> rd_cnt is tied to 0
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   start               begin-transfer pulse (ignored while busy)
//   start_addr, rd_len  first word address and word count, sampled on start
//   abort               cancel the active transfer
//   busy                transfer active (READ, DRAIN, FLUSH)
//   done                one-cycle completion pulse
//   rd_cnt              words delivered
//   mem_en/mem_addr     read request to the memory
//   mem_we, mem_din     write side, always 0
//   mem_dout            read data, valid RD_LAT cycles after mem_en
//   m_tvalid/m_tready/m_tdata/m_tlast   output stream
// ----------------------------------------------------------------------------
module jb_dbgbuf_reader
  import jb_dbgbuf_pkg::*;
#(
  parameter int AWIDTH     = JB_AWIDTH_DEF,
  parameter int DWIDTH     = JB_DWIDTH_DEF,
  parameter int RD_LAT     = JB_RD_LAT_DEF,
  parameter int FIFO_DEPTH = JB_FIFO_DEPTH_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [JB_LEN_W-1:0] start_addr,
  input  logic [JB_LEN_W-1:0] rd_len,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic [JB_LEN_W-1:0] rd_cnt,
  output logic                mem_en,
  output logic [7:0]          mem_we,
  output logic [JB_LEN_W-1:0] mem_addr,
  output logic [DWIDTH-1:0]   mem_din,
  input  logic [DWIDTH-1:0]   mem_dout,
  output logic                m_tvalid,
  input  logic                m_tready,
  output logic [DWIDTH-1:0]   m_tdata,
  output logic                m_tlast
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_LIM = (CW+1)'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_READ  = READ;
  localparam logic [1:0] ST_DRAIN = DRAIN;
  localparam logic [1:0] ST_FLUSH = FLUSH;

  logic [1:0]          state;
  logic [AWIDTH-1:0]   addr;
  logic [JB_LEN_W-1:0] len;
  logic [JB_LEN_W-1:0] issued;
  logic [JB_LEN_W-1:0] delivered;
  logic [RD_LAT-1:0]   pipe;
  logic [CW-1:0]       inflight;
  logic [CW-1:0]       fifo_count;
  logic [DWIDTH-1:0]   fifo_dout;
  logic                done_q;

  logic active;
  logic credit;
  logic issue;
  logic ret;
  logic push;
  logic pop;
  logic clear;
  logic unused_addr_hi;

  assign active = (state == ST_READ) || (state == ST_DRAIN);

  // Every issued read is counted from mem_en until it has left the pipe, so
  // inflight + fifo_count bounds the words that may still land in the FIFO.
  assign credit = ({1'b0, inflight} + {1'b0, fifo_count}) < DEPTH_LIM;

  // rst_n gating keeps requests and the stream quiet from the first reset cycle.
  assign issue = rst_n && (state == ST_READ) && !abort && credit && (issued != len);
  assign ret   = pipe[RD_LAT-1];
  assign push  = ret && active && !abort;
  assign clear = active && abort;

  assign m_tvalid = rst_n && (fifo_count != '0);
  assign m_tdata  = m_tvalid ? fifo_dout : '0;
  assign m_tlast  = m_tvalid && (delivered == len - 20'd1);
  assign pop      = m_tvalid && m_tready;

  assign busy     = (state != ST_IDLE);
  assign done     = done_q;
  assign mem_en   = issue;
  assign mem_addr = JB_LEN_W'(addr);
  assign mem_we   = '0;
  assign mem_din  = '0;

  assign unused_addr_hi = ^start_addr;

  jb_dbgbuf_rd_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DWIDTH (DWIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (push),
    .din   (mem_dout),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  // Control FSM with the issue/return bookkeeping. The pipe keeps shifting in
  // FLUSH so the in-flight count drains even though the data is thrown away.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      addr      <= '0;
      len       <= '0;
      issued    <= '0;
      delivered <= '0;
      pipe      <= '0;
      inflight  <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      pipe     <= RD_LAT'({pipe, issue});
      inflight <= inflight + CW'(issue) - CW'(ret);
      if (issue) begin
        addr   <= addr + 1'b1;
        issued <= issued + 20'd1;
      end
      if (pop) begin
        delivered <= delivered + 20'd1;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            addr      <= start_addr[AWIDTH-1:0];
            len       <= rd_len;
            issued    <= '0;
            delivered <= '0;
            if (rd_len == '0) begin
              done_q <= 1'b1;
            end else begin
              state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (abort) begin
            state <= ST_FLUSH;
          end else if (issue && (issued == len - 20'd1)) begin
            state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (abort) begin
            state <= ST_FLUSH;
          end else if (pop && m_tlast) begin
            state  <= ST_IDLE;
            done_q <= 1'b1;
          end
        end
        ST_FLUSH: begin
          if (inflight == '0) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef JB_DBGBUF_RD_CNT_EN
  logic [JB_LEN_W-1:0] rd_cnt_q;

  // Accepted-word counter; restarts with each new transfer and sticks at max.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_cnt_q <= '0;
    end else if ((state == ST_IDLE) && start) begin
      rd_cnt_q <= '0;
    end else if (pop && (rd_cnt_q != 20'hFFFFF)) begin
      rd_cnt_q <= rd_cnt_q + 20'd1;
    end
  end

  assign rd_cnt = rd_cnt_q;
`else
  assign rd_cnt = '0;
`endif

endmodule

// File: tb/tb_jb_dbgbuf_reader.sv
// ----------------------------------------------------------------------------
// tb_jb_dbgbuf_reader
// Self-checking bench for jb_dbgbuf_reader: a table of transfers (address,
// length, backpressure window, expected results) plus hand-written sequences
// for rd_len=0, abort, and reset in the middle of a transfer. The memory is a
// RD_LAT-deep pipeline returning a pattern derived from the address.
// Honours JB_DBGBUF_RD_CNT_EN for the expected rd_cnt value.
// ----------------------------------------------------------------------------
module tb_jb_dbgbuf_reader;

  localparam int AWIDTH     = 18;
  localparam int DWIDTH     = 64;
  localparam int RD_LAT     = 7;
  localparam int FIFO_DEPTH = 16;
  localparam int BUDGET     = 2000;
  localparam int NVEC       = 7;

  typedef struct {
    logic [19:0] addr;
    logic [19:0] len;
    int          stall_start;
    int          stall_len;
    int          exp_words;
    int          exp_first_valid;
    logic [79:0] exp_addrs;
    logic [19:0] exp_last_addr;
  } vec_t;

  typedef struct {
    int          words;
    int          issued;
    int          data_err;
    int          last_err;
    int          addr_err;
    int          stable_err;
    int          first_valid;
    int          last_cycle;
    int          done_cycle;
    int          done_cnt;
    int          max_out;
    logic        timeout;
    logic        busy_end;
    logic [79:0] first_addrs;
    logic [63:0] last_data;
    logic [19:0] rdcnt_end;
  } res_t;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [19:0]       start_addr;
  logic [19:0]       rd_len;
  logic              abort;
  logic              busy;
  logic              done;
  logic [19:0]       rd_cnt;
  logic              mem_en;
  logic [7:0]        mem_we;
  logic [19:0]       mem_addr;
  logic [DWIDTH-1:0] mem_din;
  logic [DWIDTH-1:0] mem_dout;
  logic              m_tvalid;
  logic              m_tready;
  logic [DWIDTH-1:0] m_tdata;
  logic              m_tlast;

  logic [DWIDTH-1:0] lat [RD_LAT];
  vec_t              vecs [NVEC];
  int                checks = 0;
  int                errors = 0;

  jb_dbgbuf_reader #(
    .AWIDTH     (AWIDTH),
    .DWIDTH     (DWIDTH),
    .RD_LAT     (RD_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .start_addr (start_addr),
    .rd_len     (rd_len),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .rd_cnt     (rd_cnt),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tdata    (m_tdata),
    .m_tlast    (m_tlast)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] memdata(input logic [19:0] a);
    return {12'hABC, a, 12'h123, a};
  endfunction

  // Memory model: data for a request appears RD_LAT cycles after mem_en;
  // slots without a request carry a poison pattern.
  always @(posedge clk) begin
    lat[0] <= mem_en ? memdata(mem_addr) : 64'hBAD0_BAD0_BAD0_BAD0;
    for (int i = 1; i < RD_LAT; i++) begin
      lat[i] <= lat[i-1];
    end
  end
  assign mem_dout = lat[RD_LAT-1];

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Runs one transfer; cycle 0 is the cycle in which start is high.
  task automatic applyStimulus(input vec_t v, output res_t r);
    int          cyc;
    int          accepted;
    logic [63:0] held;
    logic        held_v;
    r.words = 0;       r.issued = 0;      r.data_err = 0;   r.last_err = 0;
    r.addr_err = 0;    r.stable_err = 0;  r.first_valid = -1;
    r.last_cycle = -1; r.done_cycle = -1; r.done_cnt = 0;   r.max_out = 0;
    r.timeout = 1'b0;  r.busy_end = 1'b0; r.first_addrs = '0;
    r.last_data = '0;  r.rdcnt_end = '0;
    accepted = 0;
    held = '0;
    held_v = 1'b0;
    cyc = 0;
    while (cyc < BUDGET) begin
      @(negedge clk);
      start      = (cyc == 0);
      start_addr = v.addr;
      rd_len     = v.len;
      m_tready   = !((cyc >= v.stall_start) && (cyc < v.stall_start + v.stall_len));
      #1;
      if (mem_en) begin
        if (mem_addr != 20'((32'(v.addr) + 32'(r.issued)) & 32'h3FFFF)) r.addr_err++;
        if (r.issued < 4) r.first_addrs[r.issued*20 +: 20] = mem_addr;
        r.issued++;
      end
      if (held_v && (!m_tvalid || (m_tdata != held))) r.stable_err++;
      held_v = m_tvalid && !m_tready;
      held   = m_tdata;
      if (m_tvalid && (r.first_valid < 0)) r.first_valid = cyc;
      if (m_tvalid && m_tready) begin
        if (m_tdata != memdata(20'((32'(v.addr) + 32'(accepted)) & 32'h3FFFF))) r.data_err++;
        if (m_tlast != (accepted == int'(v.len) - 1)) r.last_err++;
        if (m_tlast) begin
          r.last_cycle = cyc;
          r.last_data  = m_tdata;
        end
        accepted++;
      end
      if (r.issued - accepted > r.max_out) r.max_out = r.issued - accepted;
      if (done) begin
        r.done_cnt++;
        r.done_cycle = cyc;
      end
      cyc++;
      if ((r.done_cnt > 0) && (cyc > r.done_cycle + 3)) break;
    end
    r.words     = accepted;
    r.timeout   = (r.done_cnt == 0);
    r.busy_end  = busy || m_tvalid;
    r.rdcnt_end = rd_cnt;
    start    = 1'b0;
    m_tready = 1'b1;
  endtask

  task automatic checkVector(input int i, input vec_t v, input res_t r);
    int exp_rdcnt;
`ifdef JB_DBGBUF_RD_CNT_EN
    exp_rdcnt = int'(v.len);
`else
    exp_rdcnt = 0;
`endif
    checkOutput($sformatf("v%0d_timeout", i), 64'(r.timeout), 64'd0);
    checkOutput($sformatf("v%0d_words", i), 64'(r.words), 64'(v.exp_words));
    checkOutput($sformatf("v%0d_issued", i), 64'(r.issued), 64'(v.exp_words));
    checkOutput($sformatf("v%0d_data_err", i), 64'(r.data_err), 64'd0);
    checkOutput($sformatf("v%0d_tlast_err", i), 64'(r.last_err), 64'd0);
    checkOutput($sformatf("v%0d_addr_err", i), 64'(r.addr_err), 64'd0);
    checkOutput($sformatf("v%0d_first_addrs", i), 64'(r.first_addrs[63:0]),
                64'(v.exp_addrs[63:0]));
    checkOutput($sformatf("v%0d_first_addr3", i), 64'(r.first_addrs[79:60]),
                64'(v.exp_addrs[79:60]));
    checkOutput($sformatf("v%0d_stable_err", i), 64'(r.stable_err), 64'd0);
    checkOutput($sformatf("v%0d_first_valid", i), 64'(r.first_valid),
                64'(v.exp_first_valid));
    checkOutput($sformatf("v%0d_last_data", i), r.last_data, memdata(v.exp_last_addr));
    checkOutput($sformatf("v%0d_done_delay", i), 64'(r.done_cycle - r.last_cycle), 64'd1);
    checkOutput($sformatf("v%0d_done_cnt", i), 64'(r.done_cnt), 64'd1);
    checkOutput($sformatf("v%0d_max_outstanding_ok", i),
                64'(r.max_out <= FIFO_DEPTH), 64'd1);
    checkOutput($sformatf("v%0d_idle_after", i), 64'(r.busy_end), 64'd0);
    checkOutput($sformatf("v%0d_rd_cnt", i), 64'(r.rdcnt_end), 64'(exp_rdcnt));
  endtask

  initial begin
    res_t r;
    int   dcnt, dcyc, en_cnt, v_cnt, busy_cnt;
    int   issues, cyc, abort_cyc, valid_after, en_after, busy_low, done_cnt;
    logic valid_next, pre_valid, rst_valid;

    vecs[0] = '{addr: 20'h00100, len: 20'd4,  stall_start: 0,  stall_len: 0,
                exp_words: 4,  exp_first_valid: 9,
                exp_addrs: {20'h00103, 20'h00102, 20'h00101, 20'h00100},
                exp_last_addr: 20'h00103};
    vecs[1] = '{addr: 20'h3FFFE, len: 20'd4,  stall_start: 0,  stall_len: 0,
                exp_words: 4,  exp_first_valid: 9,
                exp_addrs: {20'h00001, 20'h00000, 20'h3FFFF, 20'h3FFFE},
                exp_last_addr: 20'h00001};
    vecs[2] = '{addr: 20'h00200, len: 20'd64, stall_start: 3,  stall_len: 40,
                exp_words: 64, exp_first_valid: 9,
                exp_addrs: {20'h00203, 20'h00202, 20'h00201, 20'h00200},
                exp_last_addr: 20'h0023F};
    vecs[3] = '{addr: 20'h00010, len: 20'd5,  stall_start: 10, stall_len: 3,
                exp_words: 5,  exp_first_valid: 9,
                exp_addrs: {20'h00013, 20'h00012, 20'h00011, 20'h00010},
                exp_last_addr: 20'h00014};
    vecs[4] = '{addr: 20'h3FFF0, len: 20'd20, stall_start: 12, stall_len: 9,
                exp_words: 20, exp_first_valid: 9,
                exp_addrs: {20'h3FFF3, 20'h3FFF2, 20'h3FFF1, 20'h3FFF0},
                exp_last_addr: 20'h00003};
    vecs[5] = '{addr: 20'h00555, len: 20'd1,  stall_start: 0,  stall_len: 0,
                exp_words: 1,  exp_first_valid: 9,
                exp_addrs: {20'h00000, 20'h00000, 20'h00000, 20'h00555},
                exp_last_addr: 20'h00555};
    vecs[6] = '{addr: 20'h00040, len: 20'd6,  stall_start: 0,  stall_len: 0,
                exp_words: 6,  exp_first_valid: 9,
                exp_addrs: {20'h00043, 20'h00042, 20'h00041, 20'h00040},
                exp_last_addr: 20'h00045};

    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    m_tready   = 1'b1;
    start_addr = '0;
    rd_len     = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_mem_en", 64'(mem_en), 64'd0);
    checkOutput("rst_mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("rst_mem_we", 64'(mem_we), 64'd0);
    checkOutput("rst_mem_din", mem_din, 64'd0);
    checkOutput("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    checkOutput("rst_m_tdata", m_tdata, 64'd0);
    checkOutput("rst_m_tlast", 64'(m_tlast), 64'd0);
    checkOutput("rst_rd_cnt", 64'(rd_cnt), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven transfers
    for (int i = 0; i < NVEC - 1; i++) begin
      applyStimulus(vecs[i], r);
      checkVector(i, vecs[i], r);
    end

    // rd_len = 0: done one cycle after start, nothing else moves
    dcnt = 0; dcyc = -1; en_cnt = 0; v_cnt = 0; busy_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      start      = (c == 0);
      start_addr = 20'h00777;
      rd_len     = 20'd0;
      #1;
      if (done) begin
        dcnt++;
        dcyc = c;
      end
      if (mem_en) en_cnt++;
      if (m_tvalid) v_cnt++;
      if (busy) busy_cnt++;
    end
    start = 1'b0;
    checkOutput("len0_done_cnt", 64'(dcnt), 64'd1);
    checkOutput("len0_done_cycle", 64'(dcyc), 64'd1);
    checkOutput("len0_mem_en", 64'(en_cnt), 64'd0);
    checkOutput("len0_m_tvalid", 64'(v_cnt), 64'd0);
    checkOutput("len0_busy", 64'(busy_cnt), 64'd0);

    // Abort one cycle after the 10th issue of a 100-word transfer
    issues = 0; cyc = 0; abort_cyc = -1; valid_after = 0; en_after = 0;
    busy_low = -1; done_cnt = 0; valid_next = 1'b1;
    while (cyc < 300) begin
      @(negedge clk);
      start      = (cyc == 0);
      start_addr = 20'h01000;
      rd_len     = 20'd100;
      m_tready   = 1'b1;
      abort      = (issues == 10) && (abort_cyc < 0);
      #1;
      if (abort) begin
        abort_cyc = cyc;
        if (mem_en) en_after++;
      end else if (mem_en) begin
        issues++;
        if (abort_cyc >= 0) en_after++;
      end
      if ((abort_cyc >= 0) && (cyc == abort_cyc + 1)) valid_next = m_tvalid;
      if ((abort_cyc >= 0) && (cyc > abort_cyc) && m_tvalid) valid_after++;
      if (done) done_cnt++;
      if ((abort_cyc >= 0) && (cyc > abort_cyc) && !busy && (busy_low < 0)) busy_low = cyc;
      cyc++;
      if ((busy_low >= 0) && (cyc > busy_low + 5)) break;
    end
    abort = 1'b0;
    start = 1'b0;
    checkOutput("abort_seen", 64'(abort_cyc >= 0), 64'd1);
    checkOutput("abort_mem_en_after", 64'(en_after), 64'd0);
    checkOutput("abort_m_tvalid_next", 64'(valid_next), 64'd0);
    checkOutput("abort_m_tvalid_after", 64'(valid_after), 64'd0);
    checkOutput("abort_no_done", 64'(done_cnt), 64'd0);
    checkOutput("abort_busy_low_ok",
                64'((busy_low >= 0) && (busy_low - abort_cyc <= RD_LAT + 2)), 64'd1);

    // Transfer following the abort
    applyStimulus(vecs[NVEC-1], r);
    checkVector(NVEC - 1, vecs[NVEC-1], r);

    // Reset in the middle of a transfer with the FIFO holding data
    pre_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      start      = (c == 0);
      start_addr = 20'h02000;
      rd_len     = 20'd30;
      m_tready   = 1'b0;
      #1;
      if (c == 11) pre_valid = m_tvalid;
    end
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    rst_valid = m_tvalid;
    @(negedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    m_tready = 1'b1;
    dcnt = 0; v_cnt = 0; busy_cnt = 0; en_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      if (done) dcnt++;
      if (m_tvalid) v_cnt++;
      if (busy) busy_cnt++;
      if (mem_en) en_cnt++;
    end
    checkOutput("midrst_valid_before", 64'(pre_valid), 64'd1);
    checkOutput("midrst_valid_first_cycle", 64'(rst_valid), 64'd0);
    checkOutput("midrst_no_done", 64'(dcnt), 64'd0);
    checkOutput("midrst_no_valid", 64'(v_cnt), 64'd0);
    checkOutput("midrst_not_busy", 64'(busy_cnt), 64'd0);
    checkOutput("midrst_no_mem_en", 64'(en_cnt), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
